// File: rtl/cpu_run_controller.sv
// Run/load sequencer for the 4-bit accumulator CPU: streams a 16-byte program into
// instruction memory, then runs, single-steps or halts the core through its clock enable.
module cpu_run_controller #(
  parameter logic [7:0] MAX_CYCLES = 8'd255,
  parameter int         WORDS      = 16
) (
  input  logic       CK,
  input  logic       RST_N,
  input  logic [1:0] CMD,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [7:0] DIN,
  input  logic       DIN_VALID,
  output logic       DIN_READY,
  output logic       WE,
  output logic [3:0] WADDR,
  output logic [7:0] WDATA,
  input  logic [3:0] PC,
  input  logic       BRK_EN,
  input  logic [3:0] BRK_PC,
  output logic       CORE_EN,
  output logic       CORE_RST,
  output logic [2:0] STATE,
  output logic [7:0] CYCLES,
  output logic       BRK_HIT,
  output logic       TIMEOUT
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_STEP = 3'd3,
    S_HALT = 3'd4
  } state_t;

  localparam logic [1:0] C_LOAD = 2'd0;
  localparam logic [1:0] C_RUN  = 2'd1;
  localparam logic [1:0] C_STEP = 2'd2;
  localparam logic [1:0] C_STOP = 2'd3;
  localparam logic [3:0] LAST_ADDR = 4'(WORDS - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_we;
  logic [3:0] r_waddr;
  logic [7:0] r_wdata;
  logic       r_core_rst;
  logic [7:0] r_cycles;
  logic       r_brk_hit;
  logic       r_timeout;
  logic       r_first_run;

  logic w_cmd_acc;
  logic w_din_acc;
  logic w_brk_fire;
  logic w_core_en;
  logic w_timeout;

  // Handshakes: a command or byte transfers on a posedge where VALID and READY are both high;
  // READY depends only on registered state, never on VALID.
  assign CMD_READY = (r_state == S_IDLE) || (r_state == S_RUN) || (r_state == S_HALT);
  assign DIN_READY = (r_state == S_LOAD);
  assign w_cmd_acc = CMD_VALID && CMD_READY;
  assign w_din_acc = DIN_VALID && DIN_READY;

  // first_run masks the breakpoint so a RUN can resume from a PC parked on it.
  assign w_brk_fire = (r_state == S_RUN) && BRK_EN && (PC == BRK_PC) && !r_first_run;
  assign w_core_en  = (r_state == S_STEP) || ((r_state == S_RUN) && !w_brk_fire);
  assign w_timeout  = (r_state == S_RUN) && w_core_en &&
                      (({1'b0, r_cycles} + 9'd1) == {1'b0, MAX_CYCLES});

  always_ff @(posedge CK) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_waddr     <= 4'd0;
      r_wdata     <= 8'd0;
      r_core_rst  <= 1'b1;
      r_cycles    <= 8'd0;
      r_brk_hit   <= 1'b0;
      r_timeout   <= 1'b0;
      r_first_run <= 1'b0;
    end else begin
      r_we       <= 1'b0;
      r_core_rst <= 1'b0;
      if (w_core_en && (r_cycles != 8'hFF)) r_cycles <= r_cycles + 8'd1;

      case (r_state)
        S_IDLE, S_HALT: begin
          if (w_cmd_acc) begin
            case (CMD)
              C_LOAD: begin
                r_state   <= S_LOAD;
                r_cnt     <= 4'd0;
                r_brk_hit <= 1'b0;
                r_timeout <= 1'b0;
              end
              C_RUN: begin
                r_state     <= S_RUN;
                r_first_run <= 1'b1;
                r_brk_hit   <= 1'b0;
                r_timeout   <= 1'b0;
              end
              C_STEP: begin
                r_state   <= S_STEP;
                r_brk_hit <= 1'b0;
                r_timeout <= 1'b0;
              end
              default: r_state <= S_HALT;
            endcase
          end
        end
        S_LOAD: begin
          if (w_din_acc) begin
            r_we    <= 1'b1;
            r_waddr <= r_cnt;
            r_wdata <= DIN;
            r_cnt   <= r_cnt + 4'd1;
            if (r_cnt == LAST_ADDR) begin
              r_state    <= S_IDLE;
              r_core_rst <= 1'b1;
              r_cycles   <= 8'd0;
            end
          end
        end
        S_RUN: begin
          r_first_run <= 1'b0;
          if (w_brk_fire) begin
            r_state   <= S_HALT;
            r_brk_hit <= 1'b1;
          end else if (w_timeout) begin
            r_state   <= S_HALT;
            r_timeout <= 1'b1;
          end else if (w_cmd_acc && (CMD == C_STOP)) begin
            r_state <= S_HALT;
          end
        end
        S_STEP:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign WE       = r_we;
  assign WADDR    = r_waddr;
  assign WDATA    = r_wdata;
  assign CORE_EN  = w_core_en;
  assign CORE_RST = r_core_rst;
  assign STATE    = r_state;
  assign CYCLES   = r_cycles;
  assign BRK_HIT  = r_brk_hit;
  assign TIMEOUT  = r_timeout;

endmodule
